// File: rtl/lc2k_pkg.sv
// Shared LC-2K fetch definitions: fetch state encoding, opcode field bounds,
// the halt opcode and the 32-bit word type.
package lc2k_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  localparam int         OPC_HI      = 24;
  localparam int         OPC_LO      = 22;
  localparam logic [2:0] OPCODE_HALT = 3'b110;

  function automatic logic is_halt(input word_t instr);
    return instr[OPC_HI:OPC_LO] == OPCODE_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// LC-2K instruction fetch unit: one outstanding imem request, one-entry hold
// buffer to decode, redirect squash/drain. IFU_PERF_COUNT_EN adds fetch_count.
module instr_fetch_unit
  import lc2k_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [31:0]       fetch_instr,
  output logic [31:0]       fetch_pc,
  output logic [31:0]       fetch_pc_plus_one
`ifdef IFU_PERF_COUNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        target_q, target_d;
  word_t        instr_q, instr_d;
  word_t        fpc_q, fpc_d;
  word_t        fpc1_q, fpc1_d;
  logic         req_en_q, req_en_d;
  logic         ack;
  logic         handshake;

  // pc_q is the address on the bus; during DRAIN it stays on the squashed
  // request while target_q remembers where to go once the ack lands.
  assign imem_req          = req_en_q && (state_q == ST_FETCH || state_q == ST_DRAIN);
  assign imem_addr         = pc_q[ADDR_W-1:0];
  assign fetch_valid       = (state_q == ST_HOLD) && !redirect_valid;
  assign handshake         = fetch_valid && fetch_ready;
  assign ack               = imem_req && imem_ack;
  assign fetch_instr       = instr_q;
  assign fetch_pc          = fpc_q;
  assign fetch_pc_plus_one = fpc1_q;

  always_comb begin
    // NOTE: every _d gets its current value first so no path leaves a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    instr_d  = instr_q;
    fpc_d    = fpc_q;
    fpc1_d   = fpc1_q;
    req_en_d = 1'b1;

    if (redirect_valid) begin
      if (state_q == ST_FETCH && imem_req && !ack) begin
        state_d  = ST_DRAIN;
        target_d = redirect_target;
      end else if (state_q == ST_DRAIN && !ack) begin
        target_d = redirect_target;
      end else begin
        state_d = ST_FETCH;
        pc_d    = redirect_target;
      end
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (ack) begin
            instr_d = imem_rdata;
            fpc_d   = pc_q;
            fpc1_d  = pc_q + 32'd1;
            state_d = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          if (ack) begin
            state_d = ST_FETCH;
            pc_d    = target_q;
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            pc_d    = pc_q + 32'd1;
            state_d = is_halt(instr_q) ? ST_HALTED : ST_FETCH;
          end
        end
        ST_HALTED: ;
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
      instr_q  <= '0;
      fpc_q    <= '0;
      fpc1_q   <= '0;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      instr_q  <= instr_d;
      fpc_q    <= fpc_d;
      fpc1_q   <= fpc1_d;
      req_en_q <= req_en_d;
    end
  end

`ifdef IFU_PERF_COUNT_EN
  word_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (handshake) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, directed corner
// sequences, then randomized traffic against a fetch-stream reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_plus_one;
`ifdef IFU_PERF_COUNT_EN
  logic [31:0] fetch_count;
`endif

  instr_fetch_unit #(.RESET_PC(32'd0), .ADDR_W(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .fetch_valid       (fetch_valid),
    .fetch_ready       (fetch_ready),
    .fetch_instr       (fetch_instr),
    .fetch_pc          (fetch_pc),
    .fetch_pc_plus_one (fetch_pc_plus_one)
`ifdef IFU_PERF_COUNT_EN
    ,
    .fetch_count       (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_cnt = 0;

  typedef struct {
    logic        redirect;
    logic [31:0] target;
    logic        ready;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t        tbl [9];
  logic [31:0] mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_count(input string name);
`ifdef IFU_PERF_COUNT_EN
    check(name, fetch_count, exp_cnt);
`endif
  endtask

  task automatic ack_after(input int lat, input logic [31:0] data);
    for (int i = 0; i < lat; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
  endtask

  task automatic accept(input string name);
    fetch_ready = 1'b1;
    #1 check(name, {31'd0, fetch_valid}, 32'd1);
    @(negedge clk);
    fetch_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic idle_inputs();
    redirect_valid  = 1'b0;
    redirect_target = '0;
    imem_ack        = 1'b0;
    imem_rdata      = '0;
    fetch_ready     = 1'b0;
  endtask

  function automatic logic tb_halt(input logic [31:0] w);
    logic [2:0] op;
    op = w[24:22];
    return op == 3'b110;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        pending, halted;
    int          cnt, n_hs;
    logic [15:0] paddr;
    logic [31:0] exp_pc, w;

    tbl[0] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'hBAD0_0000, 1'b0, 16'h0, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,         1'b1, 16'h0, 1'b0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,         1'b1, 16'h0, 1'b0, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h0181_0000, 1'b1, 16'h0, 1'b0, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,         1'b0, 16'h0, 1'b1, 32'h0, 32'h0181_0000};
    tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,         1'b0, 16'h1, 1'b0, 32'h0, 32'h0};
    tbl[6] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,         1'b0, 16'h1, 1'b0, 32'h0, 32'h0};
    tbl[7] = '{1'b1, 32'h0,  1'b0, 1'b0, 32'h0,         1'b0, 16'h1, 1'b0, 32'h0, 32'h0};
    tbl[8] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,         1'b1, 16'h0, 1'b0, 32'h0, 32'h0};

    // Reset values
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_instr", fetch_instr, 32'd0);
    check("rst_pc",    fetch_pc, 32'd0);
    check("rst_pc1",   fetch_pc_plus_one, 32'd0);
    check_count("rst_count");
    @(negedge clk);
    reset = 1'b0;

    // Vector table: first fetch (halt word at pc 0), halted, restart via redirect
    for (int i = 0; i < 9; i++) begin
      redirect_valid  = tbl[i].redirect;
      redirect_target = tbl[i].target;
      fetch_ready     = tbl[i].ready;
      imem_ack        = tbl[i].ack;
      imem_rdata      = tbl[i].rdata;
      #1;
      check($sformatf("tbl%0d_req", i),   {31'd0, imem_req}, {31'd0, tbl[i].exp_req});
      check($sformatf("tbl%0d_addr", i),  {16'd0, imem_addr}, {16'd0, tbl[i].exp_addr});
      check($sformatf("tbl%0d_valid", i), {31'd0, fetch_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d_pc", i),    fetch_pc, tbl[i].exp_pc);
        check($sformatf("tbl%0d_pc1", i),   fetch_pc_plus_one, tbl[i].exp_pc + 32'd1);
        check($sformatf("tbl%0d_instr", i), fetch_instr, tbl[i].exp_instr);
        if (tbl[i].ready) exp_cnt++;
      end
      @(negedge clk);
    end
    idle_inputs();

    // Decode stalls for 5 cycles in HOLD
    ack_after(0, 32'h0000_1234);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid", {31'd0, fetch_valid}, 32'd1);
      check("stall_instr", fetch_instr, 32'h0000_1234);
      check("stall_pc",    fetch_pc, 32'd0);
      check("stall_req",   {31'd0, imem_req}, 32'd0);
      check("stall_addr",  {16'd0, imem_addr}, 32'd0);
      @(negedge clk);
    end
    accept("stall_accept");
    #1 check("stall_next_addr", {16'd0, imem_addr}, 32'd1);

    // Redirect to 0x20 while request to 4 outstanding, ack 3 cycles later
    for (int k = 1; k <= 3; k++) begin
      ack_after(0, 32'h100 + k);
      #1 check("seq_pc", fetch_pc, k);
      accept("seq_accept");
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h20;
    #1 check("drain_addr0", {16'd0, imem_addr}, 32'd4);
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("drain_req",  {31'd0, imem_req}, 32'd1);
      check("drain_addr", {16'd0, imem_addr}, 32'd4);
      @(negedge clk);
    end
    ack_after(0, 32'h0000_DEAD);
    #1;
    check("drain_valid", {31'd0, fetch_valid}, 32'd0);
    check("drain_tgt",   {16'd0, imem_addr}, 32'h20);
    ack_after(1, 32'h0000_5555);
    #1;
    check("tgt_pc",    fetch_pc, 32'h20);
    check("tgt_pc1",   fetch_pc_plus_one, 32'h21);
    check("tgt_instr", fetch_instr, 32'h0000_5555);
    accept("tgt_accept");

    // Redirect coincident with ack, then with a would-be handshake
    imem_ack        = 1'b1;
    imem_rdata      = 32'h666;
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    #1 check("ra_valid", {31'd0, fetch_valid}, 32'd0);
    @(negedge clk);
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("ra_valid2", {31'd0, fetch_valid}, 32'd0);
    check("ra_addr",   {16'd0, imem_addr}, 32'h40);
    check_count("ra_count");
    ack_after(0, 32'h777);
    #1 check("rh_pc", fetch_pc, 32'h40);
    redirect_valid  = 1'b1;
    redirect_target = 32'h60;
    fetch_ready     = 1'b1;
    #1 check("rh_valid", {31'd0, fetch_valid}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    fetch_ready    = 1'b0;
    #1;
    check("rh_valid2", {31'd0, fetch_valid}, 32'd0);
    check("rh_addr",   {16'd0, imem_addr}, 32'h60);
    check_count("rh_count");
    ack_after(0, 32'h888);
    #1 check("rh_tgt_pc", fetch_pc, 32'h60);
    accept("rh_accept");

    // PC wrap at 32'hFFFFFFFF
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    ack_after(0, 32'h0);
    #1 check("wrap_addr", {16'd0, imem_addr}, 32'h0000_FFFF);
    ack_after(0, 32'h999);
    #1;
    check("wrap_pc",  fetch_pc, 32'hFFFF_FFFF);
    check("wrap_pc1", fetch_pc_plus_one, 32'h0);
    accept("wrap_accept");
    #1 check("wrap_next", {16'd0, imem_addr}, 32'h0);

    // Halt at pc 7, then restart at 0
    redirect_valid  = 1'b1;
    redirect_target = 32'h7;
    @(negedge clk);
    redirect_valid = 1'b0;
    ack_after(0, 32'h0);
    #1 check("halt_addr", {16'd0, imem_addr}, 32'h7);
    ack_after(0, 32'h0180_0000);
    #1 check("halt_pc", fetch_pc, 32'h7);
    accept("halt_accept");
    for (int i = 0; i < 3; i++) begin
      #1;
      check("halted_req",   {31'd0, imem_req}, 32'd0);
      check("halted_valid", {31'd0, fetch_valid}, 32'd0);
      @(negedge clk);
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("restart_req",  {31'd0, imem_req}, 32'd1);
    check("restart_addr", {16'd0, imem_addr}, 32'h0);
    check_count("pre_reset_count");

    // Reset mid-DRAIN; late ack ignored
    redirect_valid  = 1'b1;
    redirect_target = 32'h10;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 check("rd_drain_addr", {16'd0, imem_addr}, 32'h0);
    #1 reset = 1'b1;
    exp_cnt = 0;
    #1;
    check("rd_req",   {31'd0, imem_req}, 32'd0);
    check("rd_valid", {31'd0, fetch_valid}, 32'd0);
    check("rd_pc",    fetch_pc, 32'd0);
    check_count("rd_count");
    imem_ack   = 1'b1;
    imem_rdata = 32'hABCD;
    @(negedge clk);
    reset = 1'b0;
    #1 check("rd_first_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rd_post_req",   {31'd0, imem_req}, 32'd1);
      check("rd_post_addr",  {16'd0, imem_addr}, 32'h0);
      check("rd_post_valid", {31'd0, fetch_valid}, 32'd0);
      @(negedge clk);
    end

    // Randomized traffic against the fetch-stream model
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if ($urandom_range(0, 7) == 0) w[24:22] = 3'b110;
      else if (tb_halt(w))           w[22] = 1'b1;
      mem[i] = w;
    end
    pending = 1'b0;
    halted  = 1'b0;
    cnt     = 0;
    paddr   = '0;
    exp_pc  = 32'h0;
    n_hs    = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pending) begin
        check("rnd_req_hold",  {31'd0, imem_req}, 32'd1);
        check("rnd_addr_hold", {16'd0, imem_addr}, {16'd0, paddr});
      end else if (imem_req) begin
        pending = 1'b1;
        cnt     = $urandom_range(0, 3);
        paddr   = imem_addr;
      end
      imem_ack        = pending && (cnt == 0);
      imem_rdata      = imem_ack ? mem[paddr[7:0]] : $urandom;
      redirect_valid  = ($urandom_range(0, 19) == 0) || (halted && $urandom_range(0, 3) == 0);
      redirect_target = $urandom_range(0, 300);
      fetch_ready     = ($urandom_range(0, 9) < 7);
      #1;
      if (redirect_valid) begin
        check("rnd_redir_valid", {31'd0, fetch_valid}, 32'd0);
        exp_pc = redirect_target;
        halted = 1'b0;
      end else if (halted) begin
        check("rnd_halt_req",   {31'd0, imem_req}, 32'd0);
        check("rnd_halt_valid", {31'd0, fetch_valid}, 32'd0);
      end else if (fetch_valid) begin
        check("rnd_pc",    fetch_pc, exp_pc);
        check("rnd_pc1",   fetch_pc_plus_one, exp_pc + 32'd1);
        check("rnd_instr", fetch_instr, mem[exp_pc[7:0]]);
        if (fetch_ready) begin
          n_hs++;
          exp_cnt++;
          halted = tb_halt(mem[exp_pc[7:0]]);
          exp_pc = exp_pc + 32'd1;
        end
      end
      if (imem_ack) pending = 1'b0;
      else if (pending) cnt--;
      @(negedge clk);
    end
    idle_inputs();
    check("rnd_handshakes_seen", {31'd0, n_hs > 20}, 32'd1);
    check_count("rnd_count");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
